// File: rtl/lab2_tdm_mux_scan.sv
// lab2_tdm_mux_scan: registered TDM channel selector with a manual mode
// (pick the channel on sel) and a timed scan mode (visit every channel for
// DWELL enabled cycles, pulsing wrap when the scan rolls back to channel 0).
module lab2_tdm_mux_scan #(
  parameter int WIDTH    = 2,
  parameter int CHANNELS = 4,
  parameter int DWELL    = 4,
  localparam int SW      = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [WIDTH*CHANNELS-1:0] din,
  input  logic [SW-1:0]             sel,
  input  logic                      mode,
  input  logic                      enable,
  output logic [WIDTH-1:0]          m,
  output logic [SW-1:0]             ch,
  output logic                      valid,
  output logic                      wrap
);

  typedef enum logic [1:0] {
    IDLE,
    MANUAL,
    SCAN
  } state_t;

  localparam logic [SW:0]   CH_LIM     = (SW+1)'(CHANNELS);
  localparam logic [SW-1:0] CH_LAST    = SW'(CHANNELS - 1);
  localparam logic [7:0]    DWELL_LAST = 8'(DWELL - 1);

  state_t           state;
  state_t           next_state;
  logic [SW-1:0]    chan;
  logic [7:0]       dwell;
  logic [SW-1:0]    chan_next;
  logic [7:0]       dwell_next;
  logic             wrap_next;
  logic             sel_ok;
  logic [SW-1:0]    scan_start;
  logic [SW-1:0]    pick;
  logic [WIDTH-1:0] pick_data;

  // sel can address past the last channel when CHANNELS is not a power of 2
  assign sel_ok     = {1'b0, sel} < CH_LIM;
  assign scan_start = sel_ok ? sel : '0;

  // FSM state register; IDLE is only reachable through reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next state follows mode on every enabled cycle; disabled cycles hold
  always_comb begin
    next_state = state;
    if (enable) begin
      next_state = mode ? SCAN : MANUAL;
    end
  end

  // Scan counters: load the start channel on entry, otherwise step the dwell
  always_comb begin
    chan_next  = chan;
    dwell_next = dwell;
    wrap_next  = 1'b0;
    if (state != SCAN) begin
      chan_next  = scan_start;
      dwell_next = '0;
    end else if (dwell == DWELL_LAST) begin
      dwell_next = '0;
      chan_next  = (chan == CH_LAST) ? '0 : chan + 1'b1;
      wrap_next  = (chan == CH_LAST);
    end else begin
      dwell_next = dwell + 8'd1;
    end
  end

  // Data mux: an out-of-range index matches no channel and yields zero
  always_comb begin
    pick      = mode ? chan_next : sel;
    pick_data = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (pick == SW'(i)) begin
        pick_data = din[i*WIDTH +: WIDTH];
      end
    end
  end

  // Counters and registered outputs; a disabled cycle only clears wrap
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      chan  <= '0;
      dwell <= '0;
      m     <= '0;
      ch    <= '0;
      valid <= 1'b0;
      wrap  <= 1'b0;
    end else if (!enable) begin
      wrap <= 1'b0;
    end else if (mode) begin
      chan  <= chan_next;
      dwell <= dwell_next;
      m     <= pick_data;
      ch    <= chan_next;
      valid <= 1'b1;
      wrap  <= wrap_next;
    end else begin
      m     <= pick_data;
      ch    <= sel;
      valid <= sel_ok;
      wrap  <= 1'b0;
    end
  end

endmodule
